// File: rtl/neuron_pkg.sv
// Shared definitions for the serial MAC neuron: default widths, FSM encoding
// and elaboration-time helper functions.
package neuron_pkg;

  localparam int W_DEF         = 17;
  localparam int FRAC_DEF      = 12;
  localparam int LUT_AW_DEF    = 11;
  localparam int LUT_SHIFT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_SAT  = 3'd2,
    ST_LUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Activation table word for ROM address addr (offset-binary index).
  // Piecewise-linear sigmoid 0.5 + v/4 clamped to [0, 1] in Q(frac).
  function automatic int hard_sigmoid(input int addr, input int lut_aw,
                                      input int lut_shift, input int frac);
    int s;
    int t;
    s = addr - (1 << (lut_aw - 1));
    t = (1 << (frac - 1)) + ((s <<< lut_shift) >>> 2);
    if (t < 0) t = 0;
    if (t > (1 << frac)) t = 1 << frac;
    return t;
  endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Activation lookup table with a one-cycle registered read. Contents are
// generated at elaboration so the neuron simulates without an external file.
module sigmoid_rom
  import neuron_pkg::*;
#(
  parameter int LUT_AW    = LUT_AW_DEF,
  parameter int W         = W_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int LUT_SHIFT = LUT_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LUT_AW-1:0] a,
  output logic [W-1:0]      q
);

  logic [W-1:0] rom_mem [2**LUT_AW];

  genvar gi;
  for (gi = 0; gi < 2**LUT_AW; gi++) begin : g_word
    assign rom_mem[gi] = W'(hard_sigmoid(gi, LUT_AW, LUT_SHIFT, FRAC));
  end

  always_ff @(posedge clk) begin
    if (en) q <= rom_mem[a];
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one pipelined multiplier accumulates sum(x_i*w_i)+bias
// over N_IN inputs, saturates the sum and maps it through the sigmoid ROM.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_IN      = 14,
  parameter int W         = W_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int LUT_AW    = LUT_AW_DEF,
  parameter int LUT_SHIFT = LUT_SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*W-1:0]           x,
  input  logic [N_IN*W-1:0]           w,
  input  logic [W-1:0]                bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W-1:0]                y,
  output logic [LUT_AW+LUT_SHIFT-1:0] acc_sat
);

  localparam int K_W   = clog2(N_IN + 1);
  localparam int ACC_W = W + K_W;
  localparam int SAT_W = LUT_AW + LUT_SHIFT;

  localparam logic signed [SAT_W-1:0] SAT_MAX = {1'b0, {(SAT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = {1'b1, {(SAT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_HI  = {{(ACC_W-SAT_W){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] ACC_LO  = {{(ACC_W-SAT_W){1'b1}}, SAT_MIN};

  state_t state_reg, state_next;

  logic [N_IN*W-1:0]         x_reg, w_reg;
  logic [K_W-1:0]            k_reg;
  logic signed [2*W-1:0]     prod_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [SAT_W-1:0]   acc_sat_reg;
  logic [W-1:0]              y_reg;

  logic signed [W-1:0]       x_mem [2**K_W];
  logic signed [W-1:0]       w_mem [2**K_W];
  logic signed [2*W-1:0]     prod_next;
  logic signed [W-1:0]       prod_slice;
  logic signed [ACC_W-1:0]   slice_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [SAT_W-1:0]   sat_next;
  logic [LUT_AW-1:0]         rom_addr;
  logic [W-1:0]              rom_q;

  // Operand table padded to a power of two so k may run one past the last input.
  genvar gi;
  for (gi = 0; gi < 2**K_W; gi++) begin : g_operand
    if (gi < N_IN) begin : g_live
      assign x_mem[gi] = x_reg[W*gi +: W];
      assign w_mem[gi] = w_reg[W*gi +: W];
    end else begin : g_pad
      assign x_mem[gi] = '0;
      assign w_mem[gi] = '0;
    end
  end

  assign prod_next  = x_mem[k_reg] * w_mem[k_reg];
  assign prod_slice = W'(prod_reg >>> FRAC);
  assign slice_ext  = {{(ACC_W-W){prod_slice[W-1]}}, prod_slice};
  assign bias_ext   = {{(ACC_W-W){bias[W-1]}}, bias};

  always_comb begin
    sat_next = acc_reg[SAT_W-1:0];
    if (acc_reg > ACC_HI)      sat_next = SAT_MAX;
    else if (acc_reg < ACC_LO) sat_next = SAT_MIN;
  end

  // Flipping the MSB turns the two's-complement index into offset binary.
  assign rom_addr = {~sat_next[SAT_W-1], sat_next[SAT_W-2:LUT_SHIFT]};

  sigmoid_rom #(
    .LUT_AW    (LUT_AW),
    .W         (W),
    .FRAC      (FRAC),
    .LUT_SHIFT (LUT_SHIFT)
  ) u_rom (
    .clk (clk),
    .en  (ce),
    .a   (rom_addr),
    .q   (rom_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else if (ce) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_MAC;
      end
      ST_MAC:  if (k_reg == K_W'(N_IN)) state_next = ST_SAT;
      ST_SAT:  state_next = ST_LUT;
      ST_LUT:  state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg       <= '0;
      w_reg       <= '0;
      k_reg       <= '0;
      prod_reg    <= '0;
      acc_reg     <= '0;
      acc_sat_reg <= '0;
      y_reg       <= '0;
    end else if (ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg   <= x;
            w_reg   <= w;
            acc_reg <= bias_ext;
            k_reg   <= '0;
          end
        end
        ST_MAC: begin
          // prod_reg lags k by one cycle, so nothing is added on the first MAC edge.
          prod_reg <= prod_next;
          k_reg    <= k_reg + K_W'(1);
          if (k_reg != '0) acc_reg <= acc_reg + slice_ext;
        end
        ST_SAT:  acc_sat_reg <= sat_next;
        ST_LUT:  y_reg <= rom_q;
        default: ;
      endcase
    end
  end

  assign y       = y_reg;
  assign acc_sat = acc_sat_reg;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq (N_IN=4): directed and random vectors
// compared against a real-arithmetic model of the neuron.
module tb_neuron_mac_seq;

  localparam int N     = 4;
  localparam int W     = 17;
  localparam int SAT_W = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [N*W-1:0]   x = '0;
  logic [N*W-1:0]   w = '0;
  logic [W-1:0]     bias = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     y;
  logic [SAT_W-1:0] acc_sat;

  int tests = 0;
  int fails = 0;
  int xv[N];
  int wv[N];
  int bv;

  neuron_mac_seq #(.N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .acc_sat   (acc_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Neuron behaviour from first principles: floor-scaled products, clamp, hard sigmoid.
  function automatic void model(output int sat_e, output int y_e);
    real acc, idx, yr;
    acc = real'(bv);
    for (int i = 0; i < N; i++)
      acc += $floor(real'(xv[i]) * real'(wv[i]) / 4096.0);
    if (acc > 4095.0)  acc = 4095.0;
    if (acc < -4096.0) acc = -4096.0;
    sat_e = int'(acc);
    idx = $floor(acc / 4.0);
    yr  = (0.5 + (idx * 4.0 / 4096.0) / 4.0) * 4096.0;
    if (yr < 0.0)    yr = 0.0;
    if (yr > 4096.0) yr = 4096.0;
    y_e = int'($floor(yr));
  endfunction

  task automatic drive_vec();
    for (int i = 0; i < N; i++) begin
      x[W*i +: W] = W'(xv[i]);
      w[W*i +: W] = W'(wv[i]);
    end
    bias = W'(bv);
  endtask

  task automatic rand_vec(input int span);
    for (int i = 0; i < N; i++) begin
      xv[i] = int'($urandom_range(2*span, 0)) - span;
      wv[i] = int'($urandom_range(2*span, 0)) - span;
    end
    bv = int'($urandom_range(8000, 0)) - 4000;
  endtask

  task automatic run_vec(input string tag, input int lat_exp, input bit toggle_ce,
                         input int hold_cycles);
    int n;
    bit done;
    int sat_e, y_e;
    @(negedge clk);
    drive_vec();
    in_valid = 1'b1;
    check({tag, "_ready_before"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = (N*W)'({$urandom, $urandom, $urandom});
    w = (N*W)'({$urandom, $urandom, $urandom});
    bias = W'($urandom);
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      ce = toggle_ce ? ((n % 2) == 1) : 1'b1;
      @(posedge clk); #1;
      n++;
      if (out_valid) done = 1'b1;
    end
    ce = 1'b1;
    model(sat_e, y_e);
    $display("[TB] %s: latency %0d acc_sat %0d y %0d (model %0d/%0d)",
             tag, n, $signed(acc_sat), y, sat_e, y_e);
    check({tag, "_latency"}, n, lat_exp);
    check({tag, "_acc_sat"}, 32'($signed(acc_sat)), sat_e);
    check({tag, "_y"}, 32'(y), y_e);
    check({tag, "_ready_done"}, 32'(in_ready), 0);
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_y"}, 32'(y), y_e);
      check({tag, "_hold_ready"}, 32'(in_ready), 0);
    end
    // Release with in_valid also high: DONE must not accept a new vector.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 0);
    check({tag, "_release_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int highs;
    #12;
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_y", 32'(y), 0);
    check("reset_acc_sat", 32'(acc_sat), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin xv[i] = 4096; wv[i] = 4096; end
    bv = 0;
    run_vec("all_one", 7, 1'b0, 20);

    for (int i = 0; i < N; i++) xv[i] = 4096;
    wv[0] = 4096; wv[1] = 4096; wv[2] = -4096; wv[3] = -4096;
    bv = 0;
    run_vec("cancel", 7, 1'b0, 0);

    for (int i = 0; i < N; i++) begin xv[i] = 4096; wv[i] = -4096; end
    bv = 0;
    run_vec("all_neg", 7, 1'b0, 0);

    for (int i = 0; i < N; i++) begin xv[i] = 0; wv[i] = 0; end
    bv = 8192;
    run_vec("bias_sat", 7, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      rand_vec((r % 2 == 0) ? 3000 : 8000);
      run_vec($sformatf("rand%0d", r), 7, 1'b0, 2);
    end

    rand_vec(3000);
    run_vec("ce_toggle", 14, 1'b1, 0);

    // Reset while the MAC is at k=2.
    rand_vec(3000);
    @(negedge clk);
    drive_vec();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midrst_busy", 32'(in_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_acc_sat", 32'(acc_sat), 0);
    @(negedge clk);
    rst = 1'b0;
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
    check("midrst_no_output", highs, 0);

    for (int i = 0; i < N; i++) begin xv[i] = 2048; wv[i] = 2048; end
    bv = 0;
    run_vec("half_sq", 7, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
